reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//   Parametrised multi-read-port integer register file for the RV32IM pipeline.
//   Provides NRD combinational read ports with write-through bypass, one write port,
//   and a per-register busy scoreboard (set at issue, cleared at writeback) for hazard detection.
//   Sits between ID (reads, issue) and WB (write); x0 is hardwired to zero.
// PARAMETERS
//   XLEN    32  data width in bits
//   NREGS   32  number of architectural registers (power of 2, >= 2)
//   NRD     2   number of read ports (1..4)
//   AW      $clog2(NREGS)  register address width (derived, not overridden)
// PORTS
//   CLK            in   1         clock, rising edge
//   RESET          in   1         asynchronous, active-low reset
//   RD_ADDR        in   NRD*AW    read addresses, port p at [p*AW +: AW]
//   RD_DATA        out  NRD*XLEN  read data, port p at [p*XLEN +: XLEN]
//   RD_BUSY        out  NRD       1 = register on port p has a pending write
//   WRITE_ENABLE   in   1         write strobe
//   WRITE_ADDRESS  in   AW        destination register
//   WRITE_DATA     in   XLEN      write value
//   ISSUE_EN       in   1         an instruction with a destination register issues this cycle
//   ISSUE_ADDR     in   AW        destination of issuing instruction
//   FLUSH          in   1         pipeline flush: clear all busy bits
//   BUSY_VEC       out  NREGS     full scoreboard, bit i = register i busy
// BEHAVIOUR
//   Reset (RESET=0, async): all registers = 0, all busy bits = 0; RD_DATA reads 0,
//     RD_BUSY = 0, BUSY_VEC = 0 while held. Writes/issues ignored while RESET=0.
//   Write: on rising CLK with WRITE_ENABLE=1 and WRITE_ADDRESS!=0, reg[WRITE_ADDRESS] <= WRITE_DATA.
//     Writes to x0 are discarded; x0 never becomes busy.
//   Read: combinational, zero cycles. RD_DATA[p] = 0 if RD_ADDR[p]==0; else WRITE_DATA if
//     WRITE_ENABLE && WRITE_ADDRESS==RD_ADDR[p] (same-cycle bypass); else stored value.
//   Busy bits, evaluated per register i at rising CLK, priority high->low:
//     FLUSH=1                              -> busy[i] <= 0 (issue and clear ignored)
//     ISSUE_EN && ISSUE_ADDR==i && i!=0    -> busy[i] <= 1 (new producer wins over same-cycle write)
//     WRITE_ENABLE && WRITE_ADDRESS==i     -> busy[i] <= 0
//     else hold.
//   FLUSH does not block the register write itself; data write still occurs.
//   RD_BUSY[p] = busy[RD_ADDR[p]] && !(WRITE_ENABLE && WRITE_ADDRESS==RD_ADDR[p]);
//     i.e. a same-cycle writeback resolves the hazard combinationally. RD_BUSY for x0 is 0.
//   Multiple read ports may address the same register; all return identical data.
//   Reset asserted mid-cycle clears state immediately; deassertion is synchronised upstream.
// STRUCTURE
//   Shared package rv32_pkg: XLEN, REG_ADDR_W, NUM_REGS constants; reg_addr_t, xlen_t typedefs.
//   Sub-module reg_file_scoreboard (NREGS busy flops, FLUSH/ISSUE/clear priority, BUSY_VEC).
//   Top holds the data array, bypass muxes (generate loop over NRD) and RD_BUSY masking.
// TESTING
//   1 Reset: RESET=0 after writing x5=0xDEADBEEF -> RD_DATA(x5)=0, BUSY_VEC=0 immediately.
//   2 Write/bypass: WE=1, WA=7, WD=0x12345678, RD_ADDR p0=7 -> RD_DATA p0=0x12345678 same
//     cycle; next cycle with WE=0 still 0x12345678.
//   3 x0: WE=1, WA=0, WD=0xFFFFFFFF; ISSUE x0 -> RD_DATA(x0)=0, BUSY_VEC[0]=0.
//   4 Scoreboard: ISSUE x3 at edge n -> RD_BUSY(x3)=1 from n; WE x3 at cycle m -> RD_BUSY=0
//     combinationally in m, BUSY_VEC[3]=0 after edge m.
//   5 Collision: same edge ISSUE x9 and WE x9=0xA5 -> after edge reg x9=0xA5, BUSY_VEC[9]=1.
//   6 Flush: busy {x1,x2,x4}, FLUSH=1 with ISSUE x6 -> after edge BUSY_VEC=0.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared constants and types for the RV32IM integer register file.
package reg_file_mp_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);

    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Read, write, issue and scoreboard signals between the pipeline and the register file.
interface reg_file_mp_if
    import reg_file_mp_pkg::*;
#(
    parameter int XLEN_P = XLEN,
    parameter int NREGS  = NUM_REGS,
    parameter int NRD    = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   RD_ADDR;
    logic [NRD*XLEN_P-1:0] RD_DATA;
    logic [NRD-1:0]      RD_BUSY;
    logic                WRITE_ENABLE;
    logic [AW-1:0]       WRITE_ADDRESS;
    logic [XLEN_P-1:0]   WRITE_DATA;
    logic                ISSUE_EN;
    logic [AW-1:0]       ISSUE_ADDR;
    logic                FLUSH;
    logic [NREGS-1:0]    BUSY_VEC;

    // Pipeline side: ID reads/issues, WB writes.
    modport master (
        output RD_ADDR, WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA,
               ISSUE_EN, ISSUE_ADDR, FLUSH,
        input  RD_DATA, RD_BUSY, BUSY_VEC
    );

    // Register file side.
    modport slave (
        input  RD_ADDR, WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA,
               ISSUE_EN, ISSUE_ADDR, FLUSH,
        output RD_DATA, RD_BUSY, BUSY_VEC
    );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy flags: set when a producer issues, cleared at its writeback,
// wiped by a pipeline flush. x0 is never busy.
module reg_file_mp_scoreboard
    import reg_file_mp_pkg::*;
#(
    parameter int NREGS = NUM_REGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    input  logic             flush,
    input  logic             write_enable,
    input  logic [AW-1:0]    write_address,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:0] busy;

    // Busy flags: flush beats issue, issue beats a same-cycle writeback clear.
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (issue_en && issue_addr == AW'(i)) begin
                    busy[i] <= 1'b1;
                end else if (write_enable && write_address == AW'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    assign busy_vec = busy;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port integer register file with write-through bypass and busy scoreboard.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int XLEN_P = XLEN,
    parameter int NREGS  = NUM_REGS,
    parameter int NRD    = 2
) (
    input  logic         CLK,
    input  logic         RESET,
    reg_file_mp_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN_P-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic              write_live;

    // A write held off by reset must not leak through the bypass path either.
    assign write_live = bus.WRITE_ENABLE && RESET;

    // Architectural register storage; x0 is never written so it stays zero.
    // NOTE: the array is reset because the architectural state must read zero after reset.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.WRITE_ENABLE && bus.WRITE_ADDRESS != '0) begin
            regs[bus.WRITE_ADDRESS] <= bus.WRITE_DATA;
        end
    end

    reg_file_mp_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .CLK           (CLK),
        .RESET         (RESET),
        .issue_en      (bus.ISSUE_EN),
        .issue_addr    (bus.ISSUE_ADDR),
        .flush         (bus.FLUSH),
        .write_enable  (bus.WRITE_ENABLE),
        .write_address (bus.WRITE_ADDRESS),
        .busy_vec      (busy)
    );

    assign bus.BUSY_VEC = busy;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]     addr;
        logic              hit;
        logic [XLEN_P-1:0] rd;

        assign addr = bus.RD_ADDR[p*AW +: AW];
        assign hit  = write_live && bus.WRITE_ADDRESS == addr;

        // Read mux: x0 reads zero, a same-cycle write bypasses, else stored value.
        // NOTE: rd gets a default first so no path leaves it unassigned and no latch is inferred.
        always_comb begin
            rd = regs[addr];
            if (addr == '0) begin
                rd = '0;
            end else if (hit) begin
                rd = bus.WRITE_DATA;
            end
        end

        assign bus.RD_DATA[p*XLEN_P +: XLEN_P] = rd;
        // A same-cycle writeback resolves the hazard; busy[0] is constant zero.
        assign bus.RD_BUSY[p] = busy[addr] && !hit;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard-style bench for reg_file_mp: stimulus queues expected outputs,
// a monitor compares them against the DUT at the falling edge.
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    typedef enum int { K_DATA, K_BUSY, K_VEC } kind_t;

    typedef struct {
        string       name;
        kind_t       kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    logic CLK;
    logic RESET;
    exp_t exp_q[$];
    int   n_chk;
    int   n_err;

    reg_file_mp_if #(.XLEN_P(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    reg_file_mp #(.XLEN_P(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: drain every queued expectation mid-cycle, after inputs settled.
    always @(negedge CLK) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.kind)
                K_DATA:  act = bus.RD_DATA[e.port*XLEN +: XLEN];
                K_BUSY:  act = {31'b0, bus.RD_BUSY[e.port]};
                default: act = bus.BUSY_VEC;
            endcase
            n_chk++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    // One cycle of stimulus, applied shortly after the rising edge.
    task automatic cyc(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ie, input logic [4:0] ia,
                       input logic fl, input logic [4:0] ra0, input logic [4:0] ra1);
        @(posedge CLK);
        #2;
        RESET             = rst;
        bus.WRITE_ENABLE  = we;
        bus.WRITE_ADDRESS = wa;
        bus.WRITE_DATA    = wd;
        bus.ISSUE_EN      = ie;
        bus.ISSUE_ADDR    = ia;
        bus.FLUSH         = fl;
        bus.RD_ADDR       = {ra1, ra0};
    endtask

    task automatic expect_out(input string name, input kind_t kind, input int port,
                              input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.port = port;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        RESET             = 1'b0;
        bus.WRITE_ENABLE  = 1'b0;
        bus.WRITE_ADDRESS = '0;
        bus.WRITE_DATA    = '0;
        bus.ISSUE_EN      = 1'b0;
        bus.ISSUE_ADDR    = '0;
        bus.FLUSH         = 1'b0;
        bus.RD_ADDR       = '0;

        // Held in reset: a write must neither bypass nor mark busy.
        cyc(0, 1, 5, 32'hDEADBEEF, 1, 5, 0, 5, 0);
        expect_out("rst_hold_data", K_DATA, 0, 32'h0);
        expect_out("rst_hold_busy", K_BUSY, 0, 32'h0);
        expect_out("rst_hold_vec",  K_VEC,  0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 5, 0);
        expect_out("rst_hold_after", K_DATA, 0, 32'h0);

        // Write x5 with issue of x5 in the same cycle: issue wins the busy bit.
        cyc(1, 1, 5, 32'hDEADBEEF, 1, 5, 0, 5, 0);
        expect_out("x5_bypass",      K_DATA, 0, 32'hDEADBEEF);
        expect_out("x5_busy_bypass", K_BUSY, 0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 5, 0);
        expect_out("x5_stored", K_DATA, 0, 32'hDEADBEEF);
        expect_out("x5_busy",   K_BUSY, 0, 32'h1);
        expect_out("x5_vec",    K_VEC,  0, 32'h0000_0020);
        // Asynchronous reset clears data and scoreboard immediately.
        cyc(0, 0, 0, 0, 0, 0, 0, 5, 0);
        expect_out("rst_x5_data", K_DATA, 0, 32'h0);
        expect_out("rst_x5_vec",  K_VEC,  0, 32'h0);
        expect_out("rst_x5_busy", K_BUSY, 0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 5, 0);
        expect_out("post_rst_x5", K_DATA, 0, 32'h0);

        // Write/bypass on both ports to x7, then stored readback.
        cyc(1, 1, 7, 32'h12345678, 0, 0, 0, 7, 7);
        expect_out("x7_bypass_p0", K_DATA, 0, 32'h12345678);
        expect_out("x7_bypass_p1", K_DATA, 1, 32'h12345678);
        cyc(1, 0, 0, 0, 0, 0, 0, 7, 0);
        expect_out("x7_stored", K_DATA, 0, 32'h12345678);

        // x0: write and issue are discarded.
        cyc(1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
        expect_out("x0_bypass_p0", K_DATA, 0, 32'h0);
        expect_out("x0_bypass_p1", K_DATA, 1, 32'h0);
        expect_out("x0_busy_p0",   K_BUSY, 0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("x0_stored", K_DATA, 0, 32'h0);
        expect_out("x0_vec",    K_VEC,  0, 32'h0);

        // Scoreboard: issue x3, then writeback clears it combinationally.
        cyc(1, 0, 0, 0, 1, 3, 0, 3, 0);
        expect_out("x3_busy_pre", K_BUSY, 0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 3, 0);
        expect_out("x3_busy_set", K_BUSY, 0, 32'h1);
        expect_out("x3_vec_set",  K_VEC,  0, 32'h0000_0008);
        cyc(1, 1, 3, 32'h33, 0, 0, 0, 3, 0);
        expect_out("x3_busy_wb",  K_BUSY, 0, 32'h0);
        expect_out("x3_data_wb",  K_DATA, 0, 32'h33);
        expect_out("x3_vec_wb",   K_VEC,  0, 32'h0000_0008);
        cyc(1, 0, 0, 0, 0, 0, 0, 3, 0);
        expect_out("x3_vec_clr",  K_VEC,  0, 32'h0);
        expect_out("x3_data_st",  K_DATA, 0, 32'h33);

        // Collision: issue and write x9 on the same edge.
        cyc(1, 1, 9, 32'hA5, 1, 9, 0, 9, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 9, 0);
        expect_out("x9_data", K_DATA, 0, 32'hA5);
        expect_out("x9_vec",  K_VEC,  0, 32'h0000_0200);
        expect_out("x9_busy", K_BUSY, 0, 32'h1);

        // Flush: busy {x1,x2,x4,x9}; flush with issue x6 and a write to x10.
        cyc(1, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 2, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 4, 0, 0, 0);
        cyc(1, 1, 10, 32'hCAFE, 1, 6, 1, 6, 10);
        expect_out("pre_flush_vec", K_VEC, 0, 32'h0000_0216);
        cyc(1, 0, 0, 0, 0, 0, 0, 6, 10);
        expect_out("flush_vec",     K_VEC,  0, 32'h0);
        expect_out("flush_busy_x6", K_BUSY, 0, 32'h0);
        expect_out("flush_write",   K_DATA, 1, 32'hCAFE);

        // Independent ports on different registers.
        cyc(1, 0, 0, 0, 0, 0, 0, 7, 9);
        expect_out("dual_p0_x7", K_DATA, 0, 32'h12345678);
        expect_out("dual_p1_x9", K_DATA, 1, 32'hA5);

        @(posedge CLK);
        @(negedge CLK);
        #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
